// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer for the MIPS core. Owns the PC register and
//   chooses the next PC from sequential, branch, jump and jr flow. Adds
//   N_IRQ edge-latched, maskable interrupt channels where the lowest index
//   wins, each with its own vector. Also provides a precise-exception vector,
//   an EPC capture register and a pipeline stall. PC[XLEN-1] is the
//   kernel-mode bit: interrupts are only taken while it is clear.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   stall      hold PC and EPC; suppress exception/interrupt entry
//   pc_src     00 pc+4, 01 branch, 10 jump, 11 jr
//   br_taken   branch condition (pc_src = 01 only)
//   br_off     sign-extended word offset
//   jump_idx   instr[25:0]
//   jr_target  register-sourced target
//   exc        current instruction raises an exception
//   irq        raw interrupt lines (level)
//   irq_mask   1 = channel enabled
//   pc         current PC
//   pc_plus4   pc + 4 (wraps)
//   kernel     pc[XLEN-1]
//   epc        return address of the last trap
//   trap       one-cycle pulse aligned with the vector PC
//   irq_id     channel taken; valid with trap when the entry was an IRQ
//   irq_ack    one-hot pulse; clears the taken channel's pending flag
//   pending    latched pending flags
module pc_sequencer #(
   parameter int unsigned     XLEN       = 32,
   parameter int unsigned     N_IRQ      = 4,
   parameter logic [XLEN-1:0] RESET_PC   = 'h0000_0000,
   parameter logic [XLEN-1:0] IRQ_BASE   = 'h8000_0004,
   parameter int unsigned     VEC_STRIDE = 8,
   parameter logic [XLEN-1:0] EXC_VEC    = 'h8000_0008,
   localparam int unsigned    ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic [1:0]       pc_src,
   input  logic             br_taken,
   input  logic [XLEN-1:0]  br_off,
   input  logic [25:0]      jump_idx,
   input  logic [XLEN-1:0]  jr_target,
   input  logic             exc,
   input  logic [N_IRQ-1:0] irq,
   input  logic [N_IRQ-1:0] irq_mask,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             kernel,
   output logic [XLEN-1:0]  epc,
   output logic             trap,
   output logic [ID_W-1:0]  irq_id,
   output logic [N_IRQ-1:0] irq_ack,
   output logic [N_IRQ-1:0] pending
);

   // Which source feeds the PC register this cycle, in priority order.
   typedef enum logic [1:0] {
      SEL_HOLD,
      SEL_EXC,
      SEL_IRQ,
      SEL_FLOW
   } pc_sel_e;

   pc_sel_e          sel;
   logic [N_IRQ-1:0] irq_prev;
   logic [N_IRQ-1:0] eligible;
   logic             irq_any;
   logic [ID_W-1:0]  take_id;
   logic [XLEN-1:0]  flow_pc;
   logic [XLEN-1:0]  pc_next;
   logic [XLEN-1:0]  epc_next;
   logic             trap_next;
   logic [N_IRQ-1:0] ack_next;
   logic [ID_W-1:0]  id_next;

   assign pc_plus4 = pc + XLEN'(4);
   assign kernel   = pc[XLEN-1];
   assign eligible = pending & irq_mask;
   assign irq_any  = |eligible;

   // Lowest-index eligible channel. Scanning downward lets the last hit win.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      take_id = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) take_id = ID_W'(i);
      end
   end

   // Ordinary control flow: sequential, branch, jump, jr.
   always_comb begin
      flow_pc = pc_plus4;
      case (pc_src)
         2'b00: flow_pc = pc_plus4;
         2'b01: flow_pc = br_taken ? (pc_plus4 + (br_off << 2)) : pc_plus4;
         2'b10: flow_pc = {pc_plus4[XLEN-1:28], jump_idx, 2'b00};
         2'b11: flow_pc = jr_target;
      endcase
   end

   // Select the source. A stall defers any trap completely, so nothing
   // (PC, EPC, trap, ack) is committed until the pipeline moves again.
   always_comb begin
      sel = SEL_FLOW;
      if (stall)                  sel = SEL_HOLD;
      else if (exc)               sel = SEL_EXC;
      else if (!kernel && irq_any) sel = SEL_IRQ;
   end

   always_comb begin
      pc_next   = flow_pc;
      epc_next  = epc;
      trap_next = 1'b0;
      ack_next  = '0;
      id_next   = irq_id;
      case (sel)
         SEL_HOLD: pc_next = pc;
         SEL_EXC: begin
            pc_next   = EXC_VEC;
            epc_next  = pc;
            trap_next = 1'b1;
         end
         SEL_IRQ: begin
            // The interrupted instruction has not executed; EPC points at it
            // so the handler's return re-executes it.
            pc_next   = IRQ_BASE + (XLEN'(take_id) * XLEN'(VEC_STRIDE));
            epc_next  = pc;
            trap_next = 1'b1;
            ack_next  = N_IRQ'(1) << take_id;
            id_next   = take_id;
         end
         SEL_FLOW: pc_next = flow_pc;
         default:  pc_next = flow_pc;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc       <= RESET_PC;
         epc      <= '0;
         pending  <= '0;
         irq_prev <= '0;
         trap     <= 1'b0;
         irq_ack  <= '0;
         irq_id   <= '0;
      end else begin
         // NOTE: registers use non-blocking assignment so every flop samples
         // the pre-edge values of the others, independent of statement order.
         irq_prev <= irq;
         // Edge capture runs even while stalled. A fresh edge on a channel
         // being acknowledged in the same cycle keeps it pending.
         pending  <= (pending & ~irq_ack) | (irq & ~irq_prev);
         pc       <= pc_next;
         epc      <= epc_next;
         trap     <= trap_next;
         irq_ack  <= ack_next;
         irq_id   <= id_next;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (default parameters).
// Each step() updates a reference model and queues the expected post-edge
// state. A monitor pops that state on the falling edge and compares it with
// the DUT. The directed scenarios also check literal PC/flag values.
module tb_pc_sequencer;

   localparam logic [31:0] K_IRQ_BASE = 32'h8000_0004;
   localparam logic [31:0] K_EXC_VEC  = 32'h8000_0008;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [1:0]  pc_src;
   logic        br_taken;
   logic [31:0] br_off;
   logic [25:0] jump_idx;
   logic [31:0] jr_target;
   logic        exc;
   logic [3:0]  irq;
   logic [3:0]  irq_mask;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        kernel;
   logic [31:0] epc;
   logic        trap;
   logic [1:0]  irq_id;
   logic [3:0]  irq_ack;
   logic [3:0]  pending;

   pc_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .pc_src    (pc_src),
      .br_taken  (br_taken),
      .br_off    (br_off),
      .jump_idx  (jump_idx),
      .jr_target (jr_target),
      .exc       (exc),
      .irq       (irq),
      .irq_mask  (irq_mask),
      .pc        (pc),
      .pc_plus4  (pc_plus4),
      .kernel    (kernel),
      .epc       (epc),
      .trap      (trap),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .pending   (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] epc;
      logic [3:0]  pend;
      logic [3:0]  ack;
      logic        trap;
      logic        kern;
      int          id;
   } exp_t;

   exp_t q[$];

   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic [3:0]  m_pend;
   logic [3:0]  m_prev;
   logic [3:0]  m_ack;
   logic        m_trap;
   int          m_id;

   task automatic model_reset();
      m_pc   = 32'h0;
      m_epc  = 32'h0;
      m_pend = 4'h0;
      m_prev = 4'h0;
      m_ack  = 4'h0;
      m_trap = 1'b0;
      m_id   = 0;
   endtask

   // Architectural rules: what the machine does with this cycle's inputs.
   task automatic model_step(input logic s, input logic [1:0] src, input logic bt,
                             input logic [31:0] off, input logic [25:0] jidx,
                             input logic [31:0] jr, input logic e,
                             input logic [3:0] ir, input logic [3:0] mk);
      logic [3:0]  new_pend;
      logic [31:0] seq;
      int          chan;
      bit          user_mode;
      new_pend = 4'h0;
      for (int i = 0; i < 4; i++) begin
         bit keep, rose;
         keep = m_pend[i] && !m_ack[i];
         rose = ir[i] && !m_prev[i];
         new_pend[i] = keep || rose;
      end
      chan = -1;
      for (int i = 0; i < 4; i++)
         if (chan < 0 && m_pend[i] && mk[i]) chan = i;
      user_mode = (m_pc < 32'h8000_0000);
      seq = m_pc + 32'd4;
      m_trap = 1'b0;
      m_ack  = 4'h0;
      if (s) begin
         // PC and EPC unchanged
      end else if (e) begin
         m_epc  = m_pc;
         m_pc   = K_EXC_VEC;
         m_trap = 1'b1;
      end else if (user_mode && chan >= 0) begin
         m_epc  = m_pc;
         m_pc   = K_IRQ_BASE + 32'(chan * 8);
         m_trap = 1'b1;
         m_ack  = 4'(1 << chan);
         m_id   = chan;
      end else begin
         case (src)
            2'd0: m_pc = seq;
            2'd1: m_pc = bt ? seq + off * 32'd4 : seq;
            2'd2: m_pc = (seq & 32'hF000_0000) | (32'(jidx) * 32'd4);
            default: m_pc = jr;
         endcase
      end
      m_pend = new_pend;
      m_prev = ir;
   endtask

   // Drive one cycle of inputs, advance the model, queue the expectation.
   task automatic step(input logic s, input logic [1:0] src, input logic bt,
                       input logic [31:0] off, input logic [25:0] jidx,
                       input logic [31:0] jr, input logic e,
                       input logic [3:0] ir, input logic [3:0] mk);
      exp_t x;
      stall = s; pc_src = src; br_taken = bt; br_off = off; jump_idx = jidx;
      jr_target = jr; exc = e; irq = ir; irq_mask = mk;
      model_step(s, src, bt, off, jidx, jr, e, ir, mk);
      x.pc = m_pc; x.pc4 = m_pc + 32'd4; x.epc = m_epc; x.pend = m_pend;
      x.ack = m_ack; x.trap = m_trap; x.kern = m_pc[31]; x.id = m_id;
      @(posedge clk);
      q.push_back(x);
      #1;
   endtask

   // Shorthands for common steps.
   task automatic seq_step(input logic [3:0] ir, input logic [3:0] mk);
      step(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, ir, mk);
   endtask

   task automatic jr_step(input logic [31:0] t, input logic [3:0] ir, input logic [3:0] mk);
      step(1'b0, 2'b11, 1'b0, 32'h0, 26'h0, t, 1'b0, ir, mk);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         e = q.pop_front();
         check("pc", pc, e.pc);
         check("pc_plus4", pc_plus4, e.pc4);
         check("epc", epc, e.epc);
         check("pending", pending, e.pend);
         check("trap", trap, e.trap);
         check("irq_ack", irq_ack, e.ack);
         check("kernel", kernel, e.kern);
         if (e.ack != 4'h0) check("irq_id", irq_id, 64'(e.id));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      reset = 1'b1; stall = 1'b0; pc_src = 2'b00; br_taken = 1'b0; br_off = '0;
      jump_idx = '0; jr_target = '0; exc = 1'b0; irq = '0; irq_mask = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_pc", pc, 64'h0);
      check("reset_trap", trap, 64'h0);
      check("reset_pending", pending, 64'h0);
      reset = 1'b0;

      // T1: reach pc=0x40 with nonzero EPC and pending, then reset asynchronously.
      for (int i = 0; i < 8; i++) seq_step(4'b1000, 4'b0000);
      check("t1_pc20", pc, 64'h20);
      step(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 4'b1000, 4'b0000);
      check("t1_epc", epc, 64'h20);
      jr_step(32'h3C, 4'b1000, 4'b0000);
      seq_step(4'b1000, 4'b0000);
      check("t1_pc40", pc, 64'h40);
      check("t1_pend_set", pending, 64'h8);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("t1_async_pc", pc, 64'h0);
      check("t1_async_epc", epc, 64'h0);
      check("t1_async_pending", pending, 64'h0);
      irq = 4'h0; irq_mask = 4'h0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();

      // T2: branch taken backwards and not taken; jump keeps upper bits.
      jr_step(32'h100, 4'h0, 4'hF);
      step(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 4'h0, 4'hF);
      check("t2_br_taken", pc, 64'hFC);
      jr_step(32'h100, 4'h0, 4'hF);
      step(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFE, 26'h0, 32'h0, 1'b0, 4'h0, 4'hF);
      check("t2_br_not_taken", pc, 64'h104);
      step(1'b0, 2'b10, 1'b0, 32'h0, 26'h3FF_FFFF, 32'h0, 1'b0, 4'h0, 4'hF);
      check("t2_jump", pc, 64'h0FFF_FFFC);

      // T3: two channels rise together; ch1 first, ch2 after returning.
      jr_step(32'h200, 4'b0110, 4'hF);
      check("t3_pc200", pc, 64'h200);
      seq_step(4'b0110, 4'hF);
      check("t3_vec_ch1", pc, 64'h8000_000C);
      check("t3_epc", epc, 64'h200);
      check("t3_ack", irq_ack, 64'h2);
      check("t3_trap", trap, 64'h1);
      check("t3_id", irq_id, 64'h1);
      seq_step(4'b0110, 4'hF);
      check("t3_ack_done", irq_ack, 64'h0);
      check("t3_pend_left", pending, 64'h4);
      jr_step(32'h200, 4'b0110, 4'hF);
      seq_step(4'b0110, 4'hF);
      check("t3_vec_ch2", pc, 64'h8000_0014);

      // T4: exception beats an eligible IRQ; kernel mode ignores IRQs.
      seq_step(4'h0, 4'hF);
      jr_step(32'h300, 4'b0001, 4'hF);
      step(1'b0, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b1, 4'b0001, 4'hF);
      check("t4_exc_vec", pc, 64'h8000_0008);
      check("t4_epc", epc, 64'h300);
      check("t4_pend0", pending[0], 64'h1);
      check("t4_no_ack", irq_ack, 64'h0);
      seq_step(4'b0011, 4'hF);
      check("t4_kernel_pc", pc, 64'h8000_000C);
      check("t4_kernel_notrap", trap, 64'h0);
      check("t4_kernel_pend", pending, 64'h3);

      // T5: stall holds PC while irq[3] rises; trap taken after the stall.
      jr_step(32'h400, 4'h0, 4'b1000);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b00, 1'b0, 32'h0, 26'h0, 32'h0, 1'b0, 4'b1000, 4'b1000);
         check("t5_stall_pc", pc, 64'h400);
         check("t5_stall_notrap", trap, 64'h0);
      end
      check("t5_pend3", pending[3], 64'h1);
      seq_step(4'b1000, 4'b1000);
      check("t5_vec_ch3", pc, 64'h8000_001C);

      // T6: irq[0] re-rises while its ack is live; then user->kernel by carry.
      jr_step(32'h500, 4'h0, 4'b0001);
      seq_step(4'h0, 4'b0001);
      check("t6_vec_ch0", pc, 64'h8000_0004);
      seq_step(4'b0001, 4'b0001);
      check("t6_pend0_kept", pending[0], 64'h1);
      jr_step(32'h7FFF_FFFC, 4'b0001, 4'h0);
      seq_step(4'b0001, 4'h0);
      check("t6_carry_pc", pc, 64'h8000_0000);
      check("t6_carry_kernel", kernel, 64'h1);
      jr_step(32'hFFFF_FFFC, 4'b0001, 4'h0);
      seq_step(4'b0001, 4'h0);
      check("t6_wrap_pc", pc, 64'h0);

      // Randomised traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic        s, e, bt;
         logic [1:0]  src;
         logic [31:0] off, jr;
         logic [25:0] jidx;
         logic [3:0]  ir, mk;
         s    = ($urandom_range(0, 7) == 0);
         e    = ($urandom_range(0, 15) == 0);
         bt   = 1'($urandom);
         src  = 2'($urandom);
         off  = 32'($signed($urandom_range(0, 63)) - 32);
         jidx = 26'($urandom);
         jr   = {1'($urandom), 31'($urandom)} & 32'hFFFF_FFFC;
         ir   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : irq;
         mk   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : irq_mask;
         step(s, src, bt, off, jidx, jr, e, ir, mk);
      end

      guard = 0;
      while (q.size() != 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #1;
      if (q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
